// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
//   Pipeline stall sequencer for the 5-stage core. It merges three sources of
//   stall requests into one hold vector for the pipeline registers:
//     - ID load-use hazards
//     - EX multi-cycle ALU operations (madd/msub/div)
//     - MEM bus waits
//   EX multi-cycle operations are tracked by a small IDLE/BUSY FSM with a
//   down-counter. MEM bus waits are bounded by a timeout that force-releases
//   the pipeline. Stall cycles are counted in a saturating counter.
//
// Ports
//   clk           clock, all state updates on posedge
//   rst           asynchronous active-high reset
//   stallreq_id   ID load-use hazard request (same-cycle)
//   ex_mc_start   1-cycle pulse: a multi-cycle op enters EX
//   ex_mc_cycles  total EX occupancy N of that op (0 is treated as 1)
//   mem_req       MEM stage bus access pending
//   mem_ack       bus completes the access this cycle
//   perf_clr      synchronous clear of stall_cycles
//   stall[5:0]    hold vector: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
//   ex_mc_busy    multi-cycle op in progress (registered state)
//   ex_mc_done    EX result valid this cycle
//   mem_err       1-cycle pulse after a MEM access was force-released
//   stall_cycles  saturating count of cycles with stall[0]=1
// -----------------------------------------------------------------------------
module stall_ctrl #(
  parameter int CNT_W       = 6,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             perf_clr,
  output logic [5:0]       stall,
  output logic             ex_mc_busy,
  output logic             ex_mc_done,
  output logic             mem_err,
  output logic [31:0]      stall_cycles
);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int MW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] n_eff;
  logic [MW-1:0]    mem_wait_cnt_q, mem_wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  logic mem_pending;
  logic timeout_hit;
  logic mem_stall;
  logic ex_stall;

  // MEM wait tracking. The cycle that reaches the timeout is released
  // (no stall) and flagged; an ack in that same cycle takes precedence
  // because mem_pending is already low then.
  always_comb begin
    mem_pending    = mem_req & ~mem_ack;
    timeout_hit    = mem_pending && (mem_wait_cnt_q == MW'(MEM_TIMEOUT - 1));
    mem_stall      = mem_pending & ~timeout_hit;
    mem_wait_cnt_d = mem_stall ? (mem_wait_cnt_q + MW'(1)) : '0;
    mem_err_d      = timeout_hit;
  end

  // Multi-cycle EX sequencing. The start cycle itself is the first EX cycle,
  // so BUSY is loaded with N-2 and finishes when the counter hits zero.
  // Done stays high in BUSY while MEM freezes EX/MEM so the result survives.
  always_comb begin
    state_d    = state_q;
    mc_cnt_d   = mc_cnt_q;
    ex_stall   = 1'b0;
    ex_mc_done = 1'b0;
    n_eff      = (ex_mc_cycles == '0) ? CNT_W'(1) : ex_mc_cycles;
    unique case (state_q)
      MC_IDLE: begin
        if (ex_mc_start) begin
          if (n_eff == CNT_W'(1)) begin
            ex_mc_done = 1'b1;
          end else begin
            ex_stall = 1'b1;
            state_d  = MC_BUSY;
            mc_cnt_d = n_eff - CNT_W'(2);
          end
        end
      end
      MC_BUSY: begin
        if (mc_cnt_q != '0) begin
          ex_stall = 1'b1;
          mc_cnt_d = mc_cnt_q - CNT_W'(1);
        end else begin
          ex_mc_done = 1'b1;
          if (!mem_stall) begin
            state_d = MC_IDLE;
          end
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

  // Later stage wins: a MEM hold also freezes everything upstream.
  always_comb begin
    stall = 6'b000000;
    if (mem_stall) begin
      stall = 6'b011111;
    end else if (ex_stall) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end
  end

  // Saturating stall counter; clear beats increment.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (perf_clr) begin
      stall_cycles_d = '0;
    end else if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= MC_IDLE;
      mc_cnt_q       <= '0;
      mem_wait_cnt_q <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mc_cnt_q       <= mc_cnt_d;
      mem_wait_cnt_q <= mem_wait_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ex_mc_busy   = (state_q == MC_BUSY);
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_ctrl
//   Self-checking bench for stall_ctrl. A reference model tracks multi-cycle
//   ops by their start cycle and length, MEM waits by the length of the
//   current unacked streak, and the stall counter as a plain integer.
//   Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_stall_ctrl;

  localparam int CNT_W       = 6;
  localparam int MEM_TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stallreq_id;
  logic             ex_mc_start;
  logic [CNT_W-1:0] ex_mc_cycles;
  logic             mem_req;
  logic             mem_ack;
  logic             perf_clr;
  logic [5:0]       stall;
  logic             ex_mc_busy;
  logic             ex_mc_done;
  logic             mem_err;
  logic [31:0]      stall_cycles;

  stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .perf_clr     (perf_clr),
    .stall        (stall),
    .ex_mc_busy   (ex_mc_busy),
    .ex_mc_done   (ex_mc_done),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int     cyc        = 0;
  bit     opActive   = 1'b0;
  int     opStart    = 0;
  int     opLen      = 0;
  int     memStreak  = 0;
  bit     errPending = 1'b0;
  longint perf       = 0;

  logic [5:0] expStall;
  logic       expBusy, expDone, expErr;
  logic [31:0] expPerf;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    opActive   = 1'b0;
    memStreak  = 0;
    errPending = 1'b0;
    perf       = 0;
  endtask

  // Computes this cycle's expected outputs from the current inputs, then
  // advances the model by one clock.
  task automatic modelStep();
    int n;
    bit hit, memStall, exStall;
    n        = (ex_mc_cycles == '0) ? 1 : int'(ex_mc_cycles);
    hit      = mem_req && !mem_ack && (memStreak + 1 == MEM_TIMEOUT);
    memStall = mem_req && !mem_ack && !hit;
    exStall  = 1'b0;
    expDone  = 1'b0;
    expBusy  = opActive;
    if (opActive) begin
      if (cyc < opStart + opLen - 1) exStall = 1'b1;
      else expDone = 1'b1;
    end else if (ex_mc_start) begin
      if (n == 1) expDone = 1'b1;
      else exStall = 1'b1;
    end
    if (memStall)         expStall = 6'b011111;
    else if (exStall)     expStall = 6'b001111;
    else if (stallreq_id) expStall = 6'b000111;
    else                  expStall = 6'b000000;
    expErr  = errPending;
    expPerf = perf[31:0];

    if (opActive) begin
      if (expDone && !memStall) opActive = 1'b0;
    end else if (ex_mc_start && n > 1) begin
      opActive = 1'b1;
      opStart  = cyc;
      opLen    = n;
    end
    memStreak  = memStall ? memStreak + 1 : 0;
    errPending = hit;
    if (perf_clr) perf = 0;
    else if (expStall[0] && perf < 64'hFFFF_FFFF) perf = perf + 1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic id, input logic st, input logic [CNT_W-1:0] n,
                               input logic req, input logic ack, input logic clr);
    @(negedge clk);
    stallreq_id  = id;
    ex_mc_start  = st;
    ex_mc_cycles = n;
    mem_req      = req;
    mem_ack      = ack;
    perf_clr     = clr;
    #2;
    modelStep();
    checkOutput($sformatf("stall@%0d", cyc), 32'(stall), 32'(expStall));
    checkOutput($sformatf("busy@%0d", cyc), 32'(ex_mc_busy), 32'(expBusy));
    checkOutput($sformatf("done@%0d", cyc), 32'(ex_mc_done), 32'(expDone));
    checkOutput($sformatf("err@%0d", cyc), 32'(mem_err), 32'(expErr));
    checkOutput($sformatf("perf@%0d", cyc), stall_cycles, expPerf);
  endtask

  task automatic idle(input int k);
    repeat (k) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    stallreq_id  = 1'b0;
    ex_mc_start  = 1'b0;
    ex_mc_cycles = '0;
    mem_req      = 1'b0;
    mem_ack      = 1'b0;
    perf_clr     = 1'b0;

    // Reset held with random inputs: registered state stays cleared.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stallreq_id  = 1'($urandom_range(0, 1));
      ex_mc_start  = 1'($urandom_range(0, 1));
      ex_mc_cycles = CNT_W'($urandom_range(0, 15));
      mem_req      = 1'($urandom_range(0, 1));
      mem_ack      = 1'($urandom_range(0, 1));
      perf_clr     = 1'($urandom_range(0, 1));
      #2;
      checkOutput("rst_busy", 32'(ex_mc_busy), 32'd0);
      checkOutput("rst_perf", stall_cycles, 32'd0);
      checkOutput("rst_err", 32'(mem_err), 32'd0);
    end
    @(negedge clk);
    {stallreq_id, ex_mc_start, mem_req, mem_ack, perf_clr} = '0;
    ex_mc_cycles = '0;
    #2;
    checkOutput("rst_stall_low", 32'(stall), 32'd0);
    checkOutput("rst_done_low", 32'(ex_mc_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    idle(2);

    // N=4 multi-cycle op: three stall cycles, done in the fourth.
    applyStimulus(1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("n4_c1_stall", 32'(stall), 32'h0F);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("n4_c2_busy", 32'(ex_mc_busy), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("n4_c3_stall", 32'(stall), 32'h0F);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("n4_c4_done", 32'(ex_mc_done), 32'd1);
    checkOutput("n4_c4_stall", 32'(stall), 32'h00);
    idle(1);
    checkOutput("n4_after_busy", 32'(ex_mc_busy), 32'd0);

    // N=1 and N=0 complete in the start cycle without stalling.
    applyStimulus(1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("n1_done", 32'(ex_mc_done), 32'd1);
    applyStimulus(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("n0_done", 32'(ex_mc_done), 32'd1);
    checkOutput("n0_stall", 32'(stall), 32'h00);
    idle(1);
    checkOutput("n0_busy", 32'(ex_mc_busy), 32'd0);

    // Op finishing while MEM holds: done stays high until MEM releases.
    applyStimulus(1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_c1_stall", 32'(stall), 32'h1F);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_c2_done", 32'(ex_mc_done), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("hold_ack_done", 32'(ex_mc_done), 32'd1);
    idle(1);
    checkOutput("hold_idle_busy", 32'(ex_mc_busy), 32'd0);

    // MEM timeout: three held cycles, fourth released, error pulse next.
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("to_c3_stall", 32'(stall), 32'h1F);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("to_c4_stall", 32'(stall), 32'h00);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("to_err", 32'(mem_err), 32'd1);
    // Ack landing on the timeout cycle wins.
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    idle(1);
    checkOutput("to_ack_noerr", 32'(mem_err), 32'd0);

    // EX start and ID request together: EX wins.
    applyStimulus(1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("ex_over_id", 32'(stall), 32'h0F);
    idle(3);

    // Stall counter: ID stalls with a clear in the middle.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'(i == 4));
    idle(1);
    checkOutput("perf_after_clr", stall_cycles, 32'd5);

    // Saturation from a preset near the top.
    @(posedge clk);
    #1;
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cycles_q;
    perf = 64'hFFFF_FFFD;
    repeat (4) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(1);
    checkOutput("perf_sat", stall_cycles, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      automatic logic req = ($urandom_range(0, 2) == 0);
      applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                    CNT_W'($urandom_range(0, 7)), req,
                    req && ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
    end

    // Reset in the middle of a long op aborts it immediately.
    applyStimulus(1'b0, 1'b1, 6'd20, 1'b0, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    {ex_mc_start, mem_req, mem_ack, perf_clr} = '0;
    stallreq_id = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(ex_mc_busy), 32'd0);
    checkOutput("midrst_stall", 32'(stall), 32'h07);
    checkOutput("midrst_perf", stall_cycles, 32'd0);
    modelReset();
    @(negedge clk);
    stallreq_id = 1'b0;
    rst = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
